uart_rx: RTL and testbench

// - Serial-to-parallel UART receiver; consumes the line driven by the UART transmitter (tx).
// - 8 data bits LSB-first, optional even/odd parity, 1 stop bit, idle-high line, same bit timing as TX.
// - Used for TX loopback checking and as the receive half of the UART; delivers one byte per frame with error flags.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, optional even/odd parity, one stop bit.
// Samples a synchronized copy of the line at mid-bit and reports each frame with error flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | half a bit in, confirming the start bit (a high sample is a glitch)
// DATA   | sampling 8 data bits at mid-bit, LSB first
// PARITY | sampling the parity bit and comparing it against the latched mode
// STOP   | sampling the stop bit, then publishing the byte and its flags
// BREAK  | stop bit was low; hold busy until the line goes high again
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       parity_en,
   input  logic       even_parity,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_en_q, par_en_d;
   logic             even_q, even_d;
   logic             par_pend_q, par_pend_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             parity_err_q, parity_err_d;
   logic             frame_err_q, frame_err_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic             bit_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         clk_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_en_q     <= 1'b0;
         even_q       <= 1'b0;
         par_pend_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_en_q     <= par_en_d;
         even_q       <= even_d;
         par_pend_q   <= par_pend_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         rx_meta_q    <= rx_meta_d;
         rx_s_q       <= rx_s_d;
      end
   end

   assign bit_tick = (clk_cnt_q == BIT_TC);

   always_comb begin
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_en_d     = par_en_q;
      even_d       = even_q;
      par_pend_d   = par_pend_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      rx_meta_d    = rx;
      rx_s_d       = rx_meta_q;

      unique case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) begin
               state_d    = S_START;
               par_en_d   = parity_en;
               even_d     = even_parity;
               par_pend_d = 1'b0;
            end
         end
         S_START: begin
            if (clk_cnt_q == HALF_TC) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               if (rx_s_q != (even_q ? ^shift_q : ~^shift_q)) begin
                  par_pend_d = 1'b1;
               end
               state_d = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               clk_cnt_d    = '0;
               data_out_d   = shift_q;
               data_valid_d = 1'b1;
               parity_err_d = par_pend_q;
               frame_err_d  = ~rx_s_q;
               // Leaving mid-stop gives half a bit of margin to catch a back-to-back start
               state_d      = rx_s_q ? S_IDLE : S_BREAK;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            clk_cnt_d = '0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a bit-level transmitter model drives rx, expected frames go to a
// scoreboard queue and are compared when data_valid pulses.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       parity_en;
   logic       even_parity;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic dv_prev  = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .parity_en  (parity_en),
      .even_parity(even_parity),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_data_out"}, 16'(data_out), 16'h0);
      chk({tag, "_data_valid"}, 16'(data_valid), 16'h0);
      chk({tag, "_parity_err"}, 16'(parity_err), 16'h0);
      chk({tag, "_frame_err"}, 16'(frame_err), 16'h0);
      chk({tag, "_rx_busy"}, 16'(rx_busy), 16'h0);
   endtask

   // Called on a negedge; holds the line for one bit time and returns on a negedge.
   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic even,
                             input logic flip_par);
      logic par;
      exp_t e;
      parity_en   = pen;
      even_parity = even;
      par         = even ? ^d : ~(^d);
      e.d  = d;
      e.pe = pen & flip_par;
      e.fe = 1'b0;
      sb.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pen) send_bit(par ^ flip_par);
      send_bit(1'b1);
      chk("busy_after_stop", 16'(rx_busy), 16'h0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         dv_prev = 1'b0;
      end else begin
         if (data_valid) begin
            chk("dv_one_cycle", 16'(dv_prev), 16'h0);
            if (sb.size() == 0) begin
               chk("dv_unexpected", 16'(data_valid), 16'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("data_out", 16'(data_out), 16'(e.d));
               chk("parity_err", 16'(parity_err), 16'(e.pe));
               chk("frame_err", 16'(frame_err), 16'(e.fe));
            end
         end
         dv_prev = data_valid;
      end
   end

   initial begin
      exp_t e;
      rst         = 1'b1;
      rx          = 1'b1;
      parity_en   = 1'b0;
      even_parity = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      repeat (CPB) @(negedge clk);

      // plain 8N1 frame
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (CPB) @(negedge clk);

      // even parity, correct then corrupted parity bit
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      repeat (CPB) @(negedge clk);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      repeat (CPB) @(negedge clk);

      // 4-clock glitch must abort in START without touching outputs
      rx = 1'b0;
      repeat (3) @(negedge clk);
      chk("glitch_busy", 16'(rx_busy), 16'h1);
      @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("glitch_idle", 16'(rx_busy), 16'h0);
      chk("glitch_data_held", 16'(data_out), 16'h3C);
      chk("glitch_perr_held", 16'(parity_err), 16'h1);

      // stop bit low for three bit times: frame error, then BREAK
      parity_en = 1'b0;
      e.d = 8'h81; e.pe = 1'b0; e.fe = 1'b1;
      sb.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(e.d[i]);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      chk("break_busy", 16'(rx_busy), 16'h1);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("break_exit", 16'(rx_busy), 16'h0);
      repeat (CPB) @(negedge clk);

      // reset in the middle of bit 4 of 0x55; the line then idles high
      e.d = 8'h55;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(e.d[i]);
      rx = e.d[4];
      repeat (CPB / 2) @(negedge clk);
      chk("pre_reset_busy", 16'(rx_busy), 16'h1);
      rst = 1'b1;
      #1;
      chk_outputs_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      chk("post_reset_idle", 16'(rx_busy), 16'h0);
      send_frame(8'h96, 1'b0, 1'b0, 1'b0);
      repeat (CPB) @(negedge clk);

      // back-to-back odd parity frames, no idle gap
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      repeat (2 * CPB) @(negedge clk);

      chk("scoreboard_empty", 16'(sb.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
